multi_tap_echo: RTL and testbench

MULTI_TAP_ECHO -- requirements
Module: multi_tap_echo

---
 rtl/multi_tap_echo_pkg.sv | 16 +
 rtl/multi_tap_echo_ram.sv | 33 +++
 rtl/multi_tap_echo.sv | 244 ++++++++++++++++++++++++
 tb/tb_multi_tap_echo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_tap_echo_pkg.sv
// Shared types for the multi-tap echo engine: FSM states and operating modes.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    EMIT
  } state_t;

  typedef enum logic {
    MODE_LOOP = 1'b0,
    MODE_LIVE = 1'b1
  } mode_t;

endpackage

// File: rtl/multi_tap_echo_ram.sv
// Sample buffer: port A is a read port with a two-stage registered output,
// port B is a write-only port. Both ports are fed from the same clock.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clka,
  input  logic                  ena,
  input  logic [ADDR_WIDTH-1:0] addra,
  output logic [RAM_WIDTH-1:0]  douta,
  input  logic                  clkb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]  dinb
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic [RAM_WIDTH-1:0] ram_a;

  // Read path: array read register followed by an output register.
  always_ff @(posedge clka) begin
    if (ena) ram_a <= mem[addra];
    douta <= ram_a;
  end

  // Write path on port B.
  always_ff @(posedge clkb) begin
    if (web) mem[addrb] <= dinb;
  end

endmodule

// File: rtl/multi_tap_echo.sv
// Multi-tap echo: stores samples in a RAM, then for every accepted sample
// reads the main sample plus NUM_TAPS delayed taps one per cycle, scales
// each tap by an arithmetic right shift and sums them into echo_out.
module multi_tap_echo
  import echo_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int NUM_TAPS     = 2,
  parameter int TAP_SPACING  = 1500,
  parameter int ATTEN_SHIFT  = 1,
  localparam int OUT_WIDTH   = SAMPLE_WIDTH + $clog2(NUM_TAPS+1)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic signed [SAMPLE_WIDTH-1:0] audio_in,
  input  logic                           audio_valid_in,
  input  logic                           record_in,
  input  logic                           mode_in,
  output logic signed [OUT_WIDTH-1:0]    signal_out,
  output logic signed [OUT_WIDTH-1:0]    echo_out,
  output logic                           out_valid,
  output logic                           busy_out,
  output logic                           overrun_out,
  output logic                           full_out
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(2**ADDR_WIDTH);
  localparam logic [3:0] CNT_LAST = 4'(NUM_TAPS);

  state_t state;
  logic [3:0] cnt;
  logic accept;

  logic mode_q, record_q;
  logic [ADDR_WIDTH-1:0] wr_ptr, rec_ptr, play_ptr;
  logic [LW-1:0] length, fill;

  logic mode_chg, rec_rise, restart, is_live, loop_wr, we;
  logic [ADDR_WIDTH-1:0] b_wr, b_rec, b_play, waddr, play_next;
  logic [LW-1:0] b_fill, b_len, new_len;

  logic [ADDR_WIDTH-1:0] cur_ptr;
  logic [LW-1:0] cur_len, cur_fill;
  mode_t cur_mode;
  logic signed [SAMPLE_WIDTH-1:0] cur_sample;

  logic [LW-1:0] tap_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic rd_en;
  logic [SAMPLE_WIDTH-1:0] ram_dout;

  logic tag_v1, tag_v2, tag_en1, tag_en2;
  logic [3:0] tag_idx1, tag_idx2;
  logic signed [OUT_WIDTH-1:0] ram_ext, live_ext, base, term, acc, main_reg;
  int shift;

  assign accept   = (state == IDLE) && audio_valid_in;
  assign busy_out = (state != IDLE);
  assign full_out = (length == DEPTH_L);

  // Pointer bases after any mode switch or record restart seen this cycle.
  always_comb begin
    mode_chg  = (mode_in != mode_q);
    rec_rise  = record_in && !record_q;
    restart   = mode_chg || rec_rise;
    is_live   = (mode_t'(mode_in) == MODE_LIVE);
    b_wr      = mode_chg ? '0 : wr_ptr;
    b_fill    = mode_chg ? '0 : fill;
    b_rec     = restart ? '0 : rec_ptr;
    b_len     = restart ? '0 : length;
    b_play    = restart ? '0 : play_ptr;
    loop_wr   = record_in && (b_len != DEPTH_L);
    we        = accept && (is_live || loop_wr);
    waddr     = is_live ? b_wr : b_rec;
    new_len   = (accept && !is_live && loop_wr) ? b_len + 1'b1 : b_len;
    play_next = (({1'b0, b_play} + 1'b1) == b_len) ? '0 : b_play + 1'b1;
  end

  // Record/play/write pointers and the snapshot taken when a sample is accepted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_q     <= 1'b0;
      record_q   <= 1'b0;
      wr_ptr     <= '0;
      rec_ptr    <= '0;
      play_ptr   <= '0;
      length     <= '0;
      fill       <= '0;
      cur_ptr    <= '0;
      cur_len    <= '0;
      cur_fill   <= '0;
      cur_mode   <= MODE_LOOP;
      cur_sample <= '0;
    end else begin
      mode_q   <= mode_in;
      record_q <= record_in;
      wr_ptr   <= b_wr;
      fill     <= b_fill;
      rec_ptr  <= b_rec;
      length   <= b_len;
      play_ptr <= b_play;
      if (accept) begin
        cur_sample <= audio_in;
        cur_mode   <= is_live ? MODE_LIVE : MODE_LOOP;
        if (is_live) begin
          wr_ptr   <= b_wr + 1'b1;
          if (b_fill != DEPTH_L) fill <= b_fill + 1'b1;
          cur_ptr  <= b_wr;
          cur_fill <= b_fill;
        end else begin
          if (loop_wr) begin
            rec_ptr <= b_rec + 1'b1;
            length  <= new_len;
          end
          if (!record_in && (b_len != '0)) play_ptr <= play_next;
          cur_ptr <= b_play;
          cur_len <= new_len;
        end
      end
    end
  end

  // Read address and contribution enable for the entry being issued.
  always_comb begin
    tap_d   = LW'(int'(cnt) * TAP_SPACING);
    rd_addr = cur_ptr;
    rd_en   = 1'b0;
    if (cnt == 4'd0) begin
      rd_en = (cur_mode == MODE_LOOP) && (cur_len != '0);
    end else if (cur_mode == MODE_LIVE) begin
      rd_addr = cur_ptr - tap_d[ADDR_WIDTH-1:0];
      rd_en   = (cur_fill >= tap_d);
    end else begin
      rd_en = (tap_d < cur_len);
      if ({1'b0, cur_ptr} >= tap_d) rd_addr = cur_ptr - tap_d[ADDR_WIDTH-1:0];
      else rd_addr = ADDR_WIDTH'({1'b0, cur_ptr} + cur_len - tap_d);
    end
  end

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH (SAMPLE_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clka (clk_in),
    .ena  (state == ISSUE),
    .addra(rd_addr),
    .douta(ram_dout),
    .clkb (clk_in),
    .web  (we),
    .addrb(waddr),
    .dinb (audio_in)
  );

  // Tags travel alongside the two-cycle RAM read so each datum knows its tap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_v1   <= 1'b0;
      tag_v2   <= 1'b0;
      tag_en1  <= 1'b0;
      tag_en2  <= 1'b0;
      tag_idx1 <= '0;
      tag_idx2 <= '0;
    end else begin
      tag_v1   <= (state == ISSUE);
      tag_en1  <= rd_en;
      tag_idx1 <= cnt;
      tag_v2   <= tag_v1;
      tag_en2  <= tag_en1;
      tag_idx2 <= tag_idx1;
    end
  end

  // Scaled contribution of the datum leaving the RAM this cycle.
  always_comb begin
    ram_ext  = OUT_WIDTH'($signed(ram_dout));
    live_ext = OUT_WIDTH'(cur_sample);
    shift    = int'(tag_idx2) * ATTEN_SHIFT;
    base     = tag_en2 ? ram_ext : '0;
    if ((tag_idx2 == 4'd0) && (cur_mode == MODE_LIVE)) base = live_ext;
    term     = base >>> shift;
  end

  // Running sum: the main entry restarts it, every tap adds into it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc      <= '0;
      main_reg <= '0;
    end else if (tag_v2) begin
      if (tag_idx2 == 4'd0) begin
        acc      <= term;
        main_reg <= term;
      end else begin
        acc <= acc + term;
      end
    end
  end

  // Control FSM with registered strobes and held output samples.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      overrun_out <= 1'b0;
      signal_out  <= '0;
      echo_out    <= '0;
    end else begin
      out_valid   <= 1'b0;
      overrun_out <= audio_valid_in && (state != IDLE);
      case (state)
        IDLE: begin
          if (audio_valid_in) begin
            state <= ISSUE;
            cnt   <= '0;
          end
        end
        ISSUE: begin
          if (cnt == CNT_LAST) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (cnt == 4'd1) begin
            state      <= EMIT;
            cnt        <= '0;
            out_valid  <= 1'b1;
            signal_out <= main_reg;
            echo_out   <= acc + term;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        EMIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_tap_echo.sv
// Directed bench for multi_tap_echo with a 16-deep buffer, two taps spaced 4.
module tb_multi_tap_echo;

  localparam int SW = 16;
  localparam int AW = 4;
  localparam int NT = 2;
  localparam int TS = 4;
  localparam int AS = 1;
  localparam int OW = SW + $clog2(NT+1);

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic signed [SW-1:0] audio_in = '0;
  logic audio_valid_in = 1'b0;
  logic record_in = 1'b0;
  logic mode_in = 1'b0;
  logic signed [OW-1:0] signal_out, echo_out;
  logic out_valid, busy_out, overrun_out, full_out;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int ovr_cnt = 0;
  int obs_sig, obs_echo, obs_lat;
  int ov0, ovr0;

  multi_tap_echo #(
    .SAMPLE_WIDTH(SW),
    .ADDR_WIDTH  (AW),
    .NUM_TAPS    (NT),
    .TAP_SPACING (TS),
    .ATTEN_SHIFT (AS)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .audio_in      (audio_in),
    .audio_valid_in(audio_valid_in),
    .record_in     (record_in),
    .mode_in       (mode_in),
    .signal_out    (signal_out),
    .echo_out      (echo_out),
    .out_valid     (out_valid),
    .busy_out      (busy_out),
    .overrun_out   (overrun_out),
    .full_out      (full_out)
  );

  always #5 clk_in = ~clk_in;

  // Count output and overrun strobes in the middle of each cycle.
  always @(negedge clk_in) begin
    if (out_valid) ov_cnt++;
    if (overrun_out) ovr_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One strobe, then wait (bounded) for out_valid and capture the outputs.
  task automatic applyStimulus(input int sample);
    bit got;
    @(negedge clk_in);
    audio_in = SW'(sample);
    audio_valid_in = 1'b1;
    got = 1'b0;
    obs_lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_in);
      #1;
      audio_valid_in = 1'b0;
      obs_lat++;
      if (out_valid) begin
        got = 1'b1;
        obs_sig = signal_out;
        obs_echo = echo_out;
      end
    end
    if (!got) checkOutput("out_valid_timeout", 0, 1);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    checkOutput("rst_signal", signal_out, 0);
    checkOutput("rst_echo", echo_out, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy_out, 0);
    checkOutput("rst_full", full_out, 0);
    checkOutput("rst_overrun", overrun_out, 0);
    rst_in = 1'b0;

    // Empty loop buffer
    applyStimulus(1234);
    checkOutput("empty_latency", obs_lat, 6);
    checkOutput("empty_signal", obs_sig, 0);
    checkOutput("empty_echo", obs_echo, 0);

    // Record 10 samples, then play them back
    @(negedge clk_in);
    record_in = 1'b1;
    for (int i = 1; i <= 10; i++) applyStimulus(i * 100);
    @(negedge clk_in);
    record_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0);
      if (i == 1) begin
        checkOutput("loop10_p1_signal", obs_sig, 100);
        checkOutput("loop10_p1_echo", obs_echo, 525);
      end
      if (i == 5) begin
        checkOutput("loop10_p5_signal", obs_sig, 500);
        checkOutput("loop10_p5_echo", obs_echo, 725);
      end
    end

    // Overfill the loop buffer
    @(negedge clk_in);
    record_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(i * 10);
      if (i == 15) checkOutput("full_after_15", full_out, 0);
      if (i == 16) checkOutput("full_after_16", full_out, 1);
    end
    checkOutput("full_after_20", full_out, 1);
    @(negedge clk_in);
    record_in = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(0);
      if (i == 1) begin
        checkOutput("full_p1_signal", obs_sig, 10);
        checkOutput("full_p1_echo", obs_echo, 97);
      end
      if (i == 16) begin
        checkOutput("full_p16_signal", obs_sig, 160);
        checkOutput("full_p16_echo", obs_echo, 240);
      end
      if (i == 17) begin
        checkOutput("full_wrap_signal", obs_sig, 10);
        checkOutput("full_wrap_echo", obs_echo, 97);
      end
    end
    checkOutput("full_held", full_out, 1);

    // Live ring delay with a constant input
    @(negedge clk_in);
    mode_in = 1'b1;
    @(negedge clk_in);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(-800);
      if (i == 1) checkOutput("live_o1_signal", obs_sig, -800);
      if (i == 1) checkOutput("live_o1_echo", obs_echo, -800);
      if (i == 4) checkOutput("live_o4_echo", obs_echo, -800);
      if (i == 5) checkOutput("live_o5_echo", obs_echo, -1200);
      if (i == 8) checkOutput("live_o8_echo", obs_echo, -1200);
      if (i == 9) checkOutput("live_o9_echo", obs_echo, -1400);
      if (i == 10) checkOutput("live_o10_echo", obs_echo, -1400);
    end
    checkOutput("live_full_low", full_out, 0);

    // Overrun: second strobe while busy is dropped
    @(negedge clk_in);
    mode_in = 1'b0;
    @(negedge clk_in);
    mode_in = 1'b1;
    @(negedge clk_in);
    ov0 = ov_cnt;
    ovr0 = ovr_cnt;
    audio_in = 16'sd1000;
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    @(negedge clk_in);
    audio_in = 16'sd2000;
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    repeat (8) @(negedge clk_in);
    checkOutput("overrun_pulses", ovr_cnt - ovr0, 1);
    checkOutput("overrun_out_valids", ov_cnt - ov0, 1);
    checkOutput("overrun_signal", signal_out, 1000);
    checkOutput("overrun_echo", echo_out, 1000);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(0);
      if (i == 4) checkOutput("overrun_a4_echo", obs_echo, 0);
      if (i == 5) checkOutput("overrun_a5_echo", obs_echo, 500);
    end

    // Reset while draining
    @(negedge clk_in);
    audio_in = 16'sd600;
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("drain_busy", busy_out, 1);
    rst_in = 1'b1;
    #1;
    checkOutput("drain_rst_signal", signal_out, 0);
    checkOutput("drain_rst_echo", echo_out, 0);
    checkOutput("drain_rst_out_valid", out_valid, 0);
    checkOutput("drain_rst_busy", busy_out, 0);
    ov0 = ov_cnt;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    checkOutput("drain_no_out_valid", ov_cnt - ov0, 0);
    applyStimulus(300);
    checkOutput("post_rst_latency", obs_lat, 6);
    checkOutput("post_rst_signal", obs_sig, 300);
    checkOutput("post_rst_echo", obs_echo, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
